// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the audio metering chain (peak, RMS, clip-detect).
package audio_meter_pkg;

    localparam int PCM_W = 16;
    localparam int MAG_W = 15;

    localparam logic [MAG_W-1:0] MAG_MAX = 15'd32767;

    // Output holding register state: EMPTY has no word offered, FULL offers o_pcm.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Unsigned maximum of two magnitudes.
    function automatic logic [MAG_W-1:0] mag_max(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcm_abs_saturate.sv
// Signed 16-bit PCM to 15-bit magnitude; -32768 saturates to 32767 so the
// result always fits in MAG_W bits.
module pcm_abs_saturate
    import audio_meter_pkg::*;
(
    input  logic signed [PCM_W-1:0] pcm,
    output logic        [MAG_W-1:0] mag
);

    logic [PCM_W-1:0] neg;

    // Magnitude select: pass-through, saturate, or two's-complement negate.
    always_comb begin
        neg = ~pcm + PCM_W'(1);
        mag = pcm[MAG_W-1:0];
        if (pcm[PCM_W-1]) begin
            if (pcm[MAG_W-1:0] == '0) begin
                mag = MAG_MAX;
            end else begin
                mag = neg[MAG_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcm_peak_detector.sv
// Window peak detector: reduces each window of 2^WINDOW_LOG2 accepted samples
// to its maximum magnitude and offers it over valid/ready. The sample side is
// never stalled; if downstream has not taken the previous word when a new
// window closes, the two are merged with max and o_overrun pulses.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds its word stable until then (o_pcm may only grow
// through a merge while waiting).
module pcm_peak_detector
    import audio_meter_pkg::*;
#(
    parameter int WINDOW_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [PCM_W-1:0] i_pcm,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic        [MAG_W-1:0] o_pcm,
    output logic                    o_overrun
);

    logic [WINDOW_LOG2-1:0] count;
    logic [MAG_W-1:0]       peak;
    logic [MAG_W-1:0]       mag;
    logic [MAG_W-1:0]       peak_next;
    logic                   accept;
    logic                   win_start;
    logic                   win_close;

    out_state_t             state;
    out_state_t             state_next;
    logic [MAG_W-1:0]       pcm_next;
    logic                   overrun_next;

    pcm_abs_saturate u_abs (
        .pcm (i_pcm),
        .mag (mag)
    );

    assign accept    = i_valid && i_ready;
    assign win_start = (count == '0);
    assign win_close = accept && (&count);
    // The first sample of a window discards the previous peak; the value
    // computed here is also the close candidate, so it always includes the
    // closing sample.
    assign peak_next = win_start ? mag : mag_max(peak, mag);

    assign o_valid = (state == OUT_FULL);

    // Input ready comes up on the first edge after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_ready <= 1'b0;
        end else begin
            i_ready <= 1'b1;
        end
    end

    // Window sample counter and running peak.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            peak  <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
            peak  <= peak_next;
        end
    end

    // Output state, held word and overrun pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= OUT_EMPTY;
            o_pcm     <= '0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_next;
            o_pcm     <= pcm_next;
            o_overrun <= overrun_next;
        end
    end

    // Output FSM next-state: load, release, fresh reload, or merge.
    always_comb begin
        state_next   = state;
        pcm_next     = o_pcm;
        overrun_next = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (win_close) begin
                    pcm_next   = peak_next;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (win_close) begin
                    if (o_ready) begin
                        pcm_next = peak_next;
                    end else begin
                        pcm_next     = mag_max(o_pcm, peak_next);
                        overrun_next = 1'b1;
                    end
                end else if (o_ready) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: begin
                state_next = OUT_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_pcm_peak_detector.sv
// Bench for pcm_peak_detector with 4-sample windows: reset, directed vector
// table, randomized traffic against a window-level model, mid-window reset.
module tb_pcm_peak_detector;

    localparam int WL  = 2;
    localparam int WIN = 1 << WL;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_valid;
    logic               i_ready;
    logic signed [15:0] i_pcm;
    logic               o_valid;
    logic               o_ready;
    logic [14:0]        o_pcm;
    logic               o_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit v;
        int pcm;
        bit r;
        bit ev;
        int epcm;
        bit eovr;
    } vec_t;

    vec_t tbl[$];

    // Model state: magnitudes of the open window, and the offered word.
    int m_win[$];
    bit m_pend;
    int m_val;
    bit m_ovr;

    // Clock.
    always #5 clk = ~clk;

    pcm_peak_detector #(.WINDOW_LOG2(WL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_pcm     (i_pcm),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_pcm     (o_pcm),
        .o_overrun (o_overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int pcm, input bit r);
        i_valid = v;
        i_pcm   = 16'(pcm);
        o_ready = r;
    endtask

    task automatic add(input bit v, input int pcm, input bit r,
                       input bit ev, input int epcm, input bit eovr);
        vec_t e;
        e.v = v; e.pcm = pcm; e.r = r; e.ev = ev; e.epcm = epcm; e.eovr = eovr;
        tbl.push_back(e);
    endtask

    function automatic int mag_of(input int s);
        if (s >= 0) return s;
        if (s == -32768) return 32767;
        return -s;
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_pend = 0;
        m_val  = 0;
        m_ovr  = 0;
    endtask

    // One accepted/idle edge at window granularity.
    task automatic model_edge(input bit v, input int s, input bit r);
        bit close;
        int cand;
        close = 0;
        cand  = 0;
        m_ovr = 0;
        if (v) begin
            m_win.push_back(mag_of(s));
            if (m_win.size() == WIN) begin
                close = 1;
                foreach (m_win[k]) if (m_win[k] > cand) cand = m_win[k];
                m_win.delete();
            end
        end
        if (m_pend && r) m_pend = 0;
        if (close) begin
            if (m_pend) begin
                if (cand > m_val) m_val = cand;
                m_ovr = 1;
            end else begin
                m_val  = cand;
                m_pend = 1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_i_ready", i_ready, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_pcm", o_pcm, 0);
        check("rst_o_overrun", o_overrun, 0);
        reset_n = 1'b1;
        step();
        check("post_rst_i_ready", i_ready, 1);
        check("post_rst_o_valid", o_valid, 0);

        // First window.
        add(1, 100, 1, 0, 0, 0);
        add(1, -300, 1, 0, 0, 0);
        add(1, 50, 1, 0, 0, 0);
        add(1, 20, 1, 1, 300, 0);
        add(0, 0, 1, 0, 300, 0);
        // Saturation.
        add(1, -32768, 1, 0, 300, 0);
        add(1, 0, 1, 0, 300, 0);
        add(1, 0, 1, 0, 300, 0);
        add(1, 0, 1, 1, 32767, 0);
        add(1, 32767, 1, 0, 32767, 0);
        add(1, -32767, 1, 0, 32767, 0);
        add(1, 1, 1, 0, 32767, 0);
        add(1, 1, 1, 1, 32767, 0);
        // Window independence.
        add(1, 5000, 1, 0, 32767, 0);
        add(1, 0, 1, 0, 32767, 0);
        add(1, 0, 1, 0, 32767, 0);
        add(1, 0, 1, 1, 5000, 0);
        add(1, 10, 1, 0, 5000, 0);
        add(1, 20, 1, 0, 5000, 0);
        add(1, 30, 1, 0, 5000, 0);
        add(1, 40, 1, 1, 40, 0);
        add(0, 0, 1, 0, 40, 0);
        // Merge with downstream stalled.
        add(1, 800, 0, 0, 40, 0);
        add(1, 0, 0, 0, 40, 0);
        add(1, 0, 0, 0, 40, 0);
        add(1, 0, 0, 1, 800, 0);
        add(1, 1200, 0, 1, 800, 0);
        add(1, 0, 0, 1, 800, 0);
        add(1, 0, 0, 1, 800, 0);
        add(1, 0, 0, 1, 1200, 1);
        add(1, 400, 0, 1, 1200, 0);
        add(1, 0, 0, 1, 1200, 0);
        add(1, 0, 0, 1, 1200, 0);
        add(1, 0, 0, 1, 1200, 1);
        add(0, 0, 1, 0, 1200, 0);
        add(0, 0, 1, 0, 1200, 0);
        // Accept and close on the same edge.
        add(1, 10, 0, 0, 1200, 0);
        add(1, 0, 0, 0, 1200, 0);
        add(1, 0, 0, 0, 1200, 0);
        add(1, 0, 0, 1, 10, 0);
        add(1, 77, 0, 1, 10, 0);
        add(1, 0, 0, 1, 10, 0);
        add(1, 0, 0, 1, 10, 0);
        add(1, 0, 1, 1, 77, 0);
        add(0, 0, 1, 0, 77, 0);

        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].pcm, tbl[n].r);
            step();
            check($sformatf("vec%0d_o_valid", n), o_valid, tbl[n].ev);
            check($sformatf("vec%0d_o_pcm", n), o_pcm, tbl[n].epcm);
            check($sformatf("vec%0d_o_overrun", n), o_overrun, tbl[n].eovr);
        end

        // Randomized traffic with sparse input and a slow consumer.
        reset_n = 1'b0;
        drive(0, 0, 0);
        #2;
        reset_n = 1'b1;
        step();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v;
            bit r;
            int s;
            int sel;
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       s = -32768;
                1:       s = 32767;
                2:       s = -32767;
                3:       s = $urandom_range(0, 15) - 8;
                default: s = $urandom_range(0, 65535) - 32768;
            endcase
            drive(v, s, r);
            step();
            model_edge(v, s, r);
            check("rnd_o_valid", o_valid, m_pend);
            check("rnd_o_pcm", o_pcm, m_val);
            check("rnd_o_overrun", o_overrun, m_ovr);
        end

        // Reset two samples into a window; the next four samples form the window.
        drive(0, 0, 1);
        step();
        step();
        drive(1, 9000, 1);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_o_valid", o_valid, 0);
        check("midrst_o_pcm", o_pcm, 0);
        check("midrst_i_ready", i_ready, 0);
        drive(0, 0, 1);
        step();
        reset_n = 1'b1;
        step();
        drive(1, 1, 1);
        step();
        drive(1, 2, 1);
        step();
        check("midrst_no_early_close", o_valid, 0);
        drive(1, 3, 1);
        step();
        drive(1, -4, 1);
        step();
        check("midrst_close_valid", o_valid, 1);
        check("midrst_close_pcm", o_pcm, 4);
        drive(0, 0, 1);
        step();
        check("midrst_released", o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
